// File: rtl/fetch_unit_if.sv
// Fetch-unit bus: harness handshake, decoder/ALU branch inputs, PC and counters out.
interface fetch_unit_if #(
  parameter int unsigned PC_W  = 10,
  parameter int unsigned CNT_W = 16
);
  logic             Start;
  logic             BranchEn;
  logic             Taken;
  logic [PC_W-1:0]  Target;
  logic             Ack;
  logic             Stall;
  logic [PC_W-1:0]  ProgCtr;
  logic             Running;
  logic             Done;
  logic [CNT_W-1:0] CycleCount;
  logic [CNT_W-1:0] InstCount;

  // Harness / decoder side
  modport master (
    output Start, BranchEn, Taken, Target, Ack, Stall,
    input  ProgCtr, Running, Done, CycleCount, InstCount
  );

  // Fetch unit side
  modport slave (
    input  Start, BranchEn, Taken, Target, Ack, Stall,
    output ProgCtr, Running, Done, CycleCount, InstCount
  );
endinterface

// File: rtl/fetch_unit.sv
// Program-counter / fetch sequencer with run/halt handshake and perf counters.
module fetch_unit #(
  parameter int unsigned PC_W       = 10,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  fetch_unit_if.slave  bus
);

  localparam logic [PC_W-1:0]  START_PC = PC_W'(START_ADDR);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t           state;
  logic [PC_W-1:0]  pc;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] inst_cnt;

  // Saturating counter increment
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Sequencer: Start restarts from any state; RUN retires one instruction per unstalled cycle
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= S_IDLE;
      pc        <= START_PC;
      cycle_cnt <= '0;
      inst_cnt  <= '0;
    end else if (bus.Start) begin
      state     <= S_ARMED;
      pc        <= START_PC;
      cycle_cnt <= '0;
      inst_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE:  state <= S_IDLE;
        S_ARMED: state <= S_RUN;
        S_RUN: begin
          cycle_cnt <= sat_inc(cycle_cnt);
          if (!bus.Stall) begin
            inst_cnt <= sat_inc(inst_cnt);
            if (bus.Ack) begin
              state <= S_HALT;
            end else if (bus.BranchEn && bus.Taken) begin
              pc <= bus.Target;
            end else begin
              pc <= pc + PC_W'(1);
            end
          end
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Status flags decoded straight from the state register
  assign bus.Running    = (state == S_RUN);
  assign bus.Done       = (state == S_HALT);
  assign bus.ProgCtr    = pc;
  assign bus.CycleCount = cycle_cnt;
  assign bus.InstCount  = inst_cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: wide instance plus a narrow (PC_W=4, CNT_W=4, START_ADDR=14) instance
// driven by the same stimulus, checked every cycle against a behavioural model.
module tb_fetch_unit;
  localparam int unsigned PC_W    = 10;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned START_A = 0;
  localparam int unsigned S_PC_W  = 4;
  localparam int unsigned S_CNT_W = 4;
  localparam int unsigned S_START = 14;

  localparam int ST_IDLE = 0, ST_ARMED = 1, ST_RUN = 2, ST_HALT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic            start = 1'b0;
  logic            br    = 1'b0;
  logic            tk    = 1'b0;
  logic            ack   = 1'b0;
  logic            stall = 1'b0;
  logic [PC_W-1:0] tgt   = '0;

  fetch_unit_if #(.PC_W(PC_W),   .CNT_W(CNT_W))   m_if ();
  fetch_unit_if #(.PC_W(S_PC_W), .CNT_W(S_CNT_W)) s_if ();

  assign m_if.Start    = start;
  assign m_if.BranchEn = br;
  assign m_if.Taken    = tk;
  assign m_if.Target   = tgt;
  assign m_if.Ack      = ack;
  assign m_if.Stall    = stall;
  assign s_if.Start    = start;
  assign s_if.BranchEn = br;
  assign s_if.Taken    = tk;
  assign s_if.Target   = tgt[S_PC_W-1:0];
  assign s_if.Ack      = ack;
  assign s_if.Stall    = stall;

  fetch_unit #(.PC_W(PC_W), .START_ADDR(START_A), .CNT_W(CNT_W)) dut_m (
    .Clk(clk), .Reset(rst_n), .bus(m_if.slave));
  fetch_unit #(.PC_W(S_PC_W), .START_ADDR(S_START), .CNT_W(S_CNT_W)) dut_s (
    .Clk(clk), .Reset(rst_n), .bus(s_if.slave));

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: index 0 = wide instance, 1 = narrow instance
  int md_st  [2] = '{ST_IDLE, ST_IDLE};
  int md_pc  [2] = '{START_A, S_START};
  int md_cyc [2] = '{0, 0};
  int md_ins [2] = '{0, 0};

  function automatic int pc_mod(input int k);
    return (k == 0) ? (1 << PC_W) : (1 << S_PC_W);
  endfunction
  function automatic int cnt_max(input int k);
    return (k == 0) ? ((1 << CNT_W) - 1) : ((1 << S_CNT_W) - 1);
  endfunction
  function automatic int start_of(input int k);
    return (k == 0) ? int'(START_A) : int'(S_START);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      md_st[k] = ST_IDLE; md_pc[k] = start_of(k); md_cyc[k] = 0; md_ins[k] = 0;
    end
  endtask

  task automatic model_step(input int k);
    if (start) begin
      md_st[k] = ST_ARMED; md_pc[k] = start_of(k); md_cyc[k] = 0; md_ins[k] = 0;
    end else if (md_st[k] == ST_ARMED) begin
      md_st[k] = ST_RUN;
    end else if (md_st[k] == ST_RUN) begin
      if (md_cyc[k] < cnt_max(k)) md_cyc[k]++;
      if (!stall) begin
        if (md_ins[k] < cnt_max(k)) md_ins[k]++;
        if (ack)            md_st[k] = ST_HALT;
        else if (br && tk)  md_pc[k] = int'(tgt) % pc_mod(k);
        else                md_pc[k] = (md_pc[k] + 1) % pc_mod(k);
      end
    end
  endtask

  always @(negedge rst_n) model_reset();

  always @(posedge clk) begin
    if (rst_n) begin
      model_step(0);
      model_step(1);
    end
  end

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_pc",      int'(m_if.ProgCtr),    md_pc[0]);
      chk("m_running", int'(m_if.Running),    int'(md_st[0] == ST_RUN));
      chk("m_done",    int'(m_if.Done),       int'(md_st[0] == ST_HALT));
      chk("m_cycles",  int'(m_if.CycleCount), md_cyc[0]);
      chk("m_insts",   int'(m_if.InstCount),  md_ins[0]);
      chk("s_pc",      int'(s_if.ProgCtr),    md_pc[1]);
      chk("s_running", int'(s_if.Running),    int'(md_st[1] == ST_RUN));
      chk("s_done",    int'(s_if.Done),       int'(md_st[1] == ST_HALT));
      chk("s_cycles",  int'(s_if.CycleCount), md_cyc[1]);
      chk("s_insts",   int'(s_if.InstCount),  md_ins[1]);
    end
  end

  // Drive one cycle of inputs; returns just after the following falling edge
  task automatic step(input logic s, input logic b, input logic t, input int g,
                      input logic a, input logic st);
    start = s; br = b; tk = t; tgt = PC_W'(g); ack = a; stall = st;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic plain(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic restart();
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Asynchronous reset at power-up
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pc",      int'(m_if.ProgCtr),    0);
    chk("rst_running", int'(m_if.Running),    0);
    chk("rst_done",    int'(m_if.Done),       0);
    chk("rst_s_pc",    int'(s_if.ProgCtr),    14);
    @(negedge clk); #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // IDLE holds
    plain(3);
    chk("idle_pc",      int'(m_if.ProgCtr), 0);
    chk("idle_running", int'(m_if.Running), 0);

    // Start two cycles, five plain instructions, then Ack
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("run_first_pc", int'(m_if.ProgCtr), 0);
    chk("run_first_rn", int'(m_if.Running), 1);
    for (int i = 1; i <= 5; i++) begin
      step(0, 0, 0, 0, 0, 0);
      chk("seq_pc", int'(m_if.ProgCtr), i);
    end
    step(0, 0, 0, 0, 1, 0);
    chk("halt_done",  int'(m_if.Done),       1);
    chk("halt_pc",    int'(m_if.ProgCtr),    5);
    chk("halt_insts", int'(m_if.InstCount),  6);
    chk("halt_cyc",   int'(m_if.CycleCount), 6);

    // HALT ignores everything but Start
    for (int i = 0; i < 4; i++)
      step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 1023)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    chk("halt_hold_pc", int'(m_if.ProgCtr), 5);

    // Start from HALT with noisy branch/ack
    step(1, 1, 1, 77, 1, 0);
    chk("rearm_pc",   int'(m_if.ProgCtr),   0);
    chk("rearm_done", int'(m_if.Done),      0);
    chk("rearm_ins",  int'(m_if.InstCount), 0);
    step(0, 1, 1, 77, 1, 0);
    chk("rearm_run", int'(m_if.Running), 1);

    // Branch behaviour at PC=10
    plain(10);
    chk("br_pre_pc", int'(m_if.ProgCtr), 10);
    step(0, 1, 1, 200, 0, 0);
    chk("br_taken", int'(m_if.ProgCtr), 200);
    step(0, 1, 1, 10, 0, 0);
    step(0, 1, 0, 200, 0, 0);
    chk("br_not_taken", int'(m_if.ProgCtr), 11);
    step(0, 1, 1, 10, 0, 0);
    step(0, 1, 1, 200, 1, 0);
    chk("br_ack_pc",   int'(m_if.ProgCtr), 10);
    chk("br_ack_done", int'(m_if.Done),    1);

    // Stall at PC=4 with Ack ignored during the stall
    restart();
    plain(4);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 1);
    step(0, 1, 1, 300, 0, 1);
    chk("stall_pc",  int'(m_if.ProgCtr),    4);
    chk("stall_cyc", int'(m_if.CycleCount), 7);
    chk("stall_ins", int'(m_if.InstCount),  4);
    chk("stall_rn",  int'(m_if.Running),    1);
    step(0, 0, 0, 0, 1, 0);
    chk("stall_halt", int'(m_if.Done),      1);
    chk("stall_hins", int'(m_if.InstCount), 5);

    // Start coincident with Ack: Start wins, Done never asserts
    restart();
    plain(2);
    step(1, 0, 0, 0, 1, 0);
    chk("sa_pc",   int'(m_if.ProgCtr), 0);
    chk("sa_done", int'(m_if.Done),    0);
    step(0, 0, 0, 0, 0, 0);
    chk("sa_done2", int'(m_if.Done),    0);
    chk("sa_run",   int'(m_if.Running), 1);

    // Asynchronous reset mid-RUN at PC=37
    restart();
    plain(37);
    chk("pre_rst_pc", int'(m_if.ProgCtr), 37);
    rst_n = 1'b0;
    #1;
    chk("arst_pc",  int'(m_if.ProgCtr),    0);
    chk("arst_rn",  int'(m_if.Running),    0);
    chk("arst_dn",  int'(m_if.Done),       0);
    chk("arst_cyc", int'(m_if.CycleCount), 0);
    chk("arst_ins", int'(m_if.InstCount),  0);
    @(negedge clk); #1;
    rst_n = 1'b1;

    // Narrow instance: PC wrap from 14 and counter saturation at 15
    restart();
    chk("s_wrap0", int'(s_if.ProgCtr), 14);
    step(0, 0, 0, 0, 0, 0);
    chk("s_wrap1", int'(s_if.ProgCtr), 15);
    step(0, 0, 0, 0, 0, 0);
    chk("s_wrap2", int'(s_if.ProgCtr), 0);
    step(0, 0, 0, 0, 0, 0);
    chk("s_wrap3", int'(s_if.ProgCtr), 1);
    plain(17);
    chk("s_sat_cyc", int'(s_if.CycleCount), 15);
    chk("s_sat_ins", int'(s_if.InstCount),  15);
    chk("m_cyc20",   int'(m_if.CycleCount), 20);
    chk("m_pc20",    int'(m_if.ProgCtr),    20);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program-counter / fetch sequencer that drives the instruction ROM address.
- Consumes the decoder's branch-enable and done signals, plus the ALU condition and branch target, to pick the next PC each cycle.
- Owns run/halt sequencing on the Start/Done handshake with the test harness.
- Provides cycle and retired-instruction counters for performance reporting.

Parameters:
PC_W, 10, width of program counter / instruction ROM address
START_ADDR, 0, PC value loaded on reset and on Start
CNT_W, 16, width of CycleCount and InstCount

Ports:
Clk  input  1  system clock, all state updates on rising edge
Reset  input  1  asynchronous, active-low reset (0 = reset asserted)
Start  input  1  harness start/restart request, level-sensitive
BranchEn  input  1  current instruction is a branch (from decoder)
Taken  input  1  branch condition true (from ALU flags)
Target  input  PC_W  absolute branch target (from branch LUT)
Ack  input  1  current instruction is the done instruction (from decoder)
Stall  input  1  hold current instruction this cycle
ProgCtr  output  PC_W  instruction ROM address (registered)
Running  output  1  1 while in RUN
Done  output  1  1 while in HALT
CycleCount  output  CNT_W  cycles spent in RUN
InstCount  output  CNT_W  instructions retired

Behaviour:
- One clock (Clk). Reset is asynchronous and active-low.
- Reset (Reset=0), applied immediately regardless of clock or state:
  - state=IDLE, ProgCtr=START_ADDR, Running=0, Done=0.
  - CycleCount=0, InstCount=0.
  - Reset mid-RUN aborts the program with no partial update.
- States: IDLE, ARMED, RUN, HALT. Running = (state==RUN). Done = (state==HALT). Both are decoded from registered state.
- Start=1 in any state (highest priority after reset):
  - next state=ARMED, ProgCtr<=START_ADDR, both counters<=0.
- IDLE with Start=0: hold indefinitely. No PC or counter change.
- ARMED with Start=0: next state=RUN, PC unchanged (=START_ADDR). First instruction is fetched in the first RUN cycle.
- RUN, per cycle, in priority order:
  - Stall=1: PC holds, InstCount holds, CycleCount increments. Ack, BranchEn and Taken are ignored.
  - Ack=1: next state=HALT, PC holds, InstCount+1, CycleCount+1. Ack overrides BranchEn.
  - BranchEn=1 and Taken=1: PC<=Target, InstCount+1, CycleCount+1.
  - Otherwise, including BranchEn=1 with Taken=0: PC<=PC+1, InstCount+1, CycleCount+1.
- PC arithmetic is modulo 2^PC_W: PC=2^PC_W-1 increments to 0. No error flag.
- Counters saturate at 2^CNT_W-1; they never wrap.
- HALT with Start=0: PC, counters and Done hold indefinitely. All other inputs are ignored.
- Latency: ProgCtr reflects a branch decision on the rising edge after the branch instruction is presented. ROM read is combinational from ProgCtr, so there is no bubble and every cycle fetches.
- Branch inputs in IDLE/ARMED/HALT are don't-care and must not affect state.
- Start asserted in the same cycle as Ack: Start wins, giving ARMED with PC=START_ADDR. Done never pulses.

Test Plan:
- Reset=0 mid-RUN at PC=37 -> ProgCtr=0, Running=0, Done=0, counters=0 asynchronously, before the next edge.
- Start high 2 cycles then low, 5 plain instructions then Ack (no stalls) -> ProgCtr runs 0,1,2,3,4,5. Done=1 the cycle after Ack, ProgCtr holds 5. InstCount=6, CycleCount=6.
- At PC=10: BranchEn=1, Taken=1, Target=200 -> next PC=200. Repeat with Taken=0 -> next PC=11. With BranchEn=1, Taken=1, Ack=1 -> HALT, PC holds 10.
- Stall=1 for 3 cycles at PC=4 -> PC stays 4. CycleCount +3, InstCount +0. Ack asserted during stall is ignored; Ack after stall drops causes HALT.
- PC_W=4, free-run from START_ADDR=14 -> 14, 15, 0, 1. Preload CycleCount near 2^CNT_W-1 (CNT_W=4, 20 cycles) -> saturates at 15.
- In HALT, raise Start together with random BranchEn/Ack -> ARMED, PC=START_ADDR, counters 0, Done=0. After Start drops, RUN resumes from START_ADDR.
